tanh_lut_arbiter: RTL and testbench

- Round-robin arbiter sharing one tanh activation ROM (registered address, combinational read) among NUM_REQ neuron requesters.
- Accepts one lookup per cycle over a valid/ready handshake and drives the ROM address.
- Tracks in-flight lookups through the ROM latency with a tag pipeline, then returns each result to its originating requester as a one-cycle pulse.
- Sits between the neuron array and the shared activation ROM.

---
 rtl/tanh_lut_arbiter.sv | 127 ++++++++++++
 tb/tb_tanh_lut_arbiter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tanh_lut_arbiter.sv
// rtl/tanh_lut_arbiter.sv - round-robin arbiter sharing one tanh ROM among NUM_REQ requesters
// Optional TANH_ARB_PERF_EN adds saturating lookup_cnt / stall_cnt counters.
module tanh_lut_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int IN_WIDTH   = 10,
    parameter int DATA_WIDTH = 16,
    parameter int ROM_LAT    = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        en,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*IN_WIDTH-1:0] req_x,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic [IN_WIDTH-1:0]         rom_x,
    input  logic [DATA_WIDTH-1:0]       rom_out,
    output logic [NUM_REQ-1:0]          rsp_valid,
    output logic [DATA_WIDTH-1:0]       rsp_data,
    output logic                        busy
`ifdef TANH_ARB_PERF_EN
    ,
    output logic [31:0]                 lookup_cnt,
    output logic [31:0]                 stall_cnt
`endif
);
    localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int DEPTH = ROM_LAT + 1;

    logic [ID_W-1:0]            ptr_q, ptr_d;
    logic [IN_WIDTH-1:0]        rom_x_q, rom_x_d;
    logic [DEPTH-1:0]           tag_v_q, tag_v_d;
    logic [DEPTH-1:0][ID_W-1:0] tag_id_q, tag_id_d;
    logic [NUM_REQ-1:0]         rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0]      rsp_data_q, rsp_data_d;
    logic                       busy_q, busy_d;
    logic                       xfer;
    logic [ID_W-1:0]            gnt_id;

    // Search starts one past the last winner so each requester gets a turn.
    always_comb begin
        logic [ID_W-1:0] idx;
        idx       = '0;
        req_ready = '0;
        xfer      = 1'b0;
        gnt_id    = '0;
        if (en) begin
            for (int k = 1; k <= NUM_REQ; k++) begin
                idx = ID_W'((int'(ptr_q) + k) % NUM_REQ);
                if (!xfer && req_valid[idx]) begin
                    xfer           = 1'b1;
                    gnt_id         = idx;
                    req_ready[idx] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        ptr_d       = xfer ? gnt_id : ptr_q;
        rom_x_d     = xfer ? req_x[int'(gnt_id)*IN_WIDTH +: IN_WIDTH] : rom_x_q;
        tag_v_d     = {tag_v_q[DEPTH-2:0], xfer};
        tag_id_d    = {tag_id_q[DEPTH-2:0], gnt_id};
        rsp_valid_d = '0;
        rsp_data_d  = rsp_data_q;
        if (tag_v_q[DEPTH-1]) begin
            rsp_valid_d[tag_id_q[DEPTH-1]] = 1'b1;
            rsp_data_d                     = rom_out;
        end
        // Stays high through the response cycle, dropping the cycle after it.
        busy_d = xfer | (|tag_v_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q       <= ID_W'(NUM_REQ - 1);
            rom_x_q     <= '0;
            tag_v_q     <= '0;
            tag_id_q    <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            busy_q      <= 1'b0;
        end else begin
            ptr_q       <= ptr_d;
            rom_x_q     <= rom_x_d;
            tag_v_q     <= tag_v_d;
            tag_id_q    <= tag_id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            busy_q      <= busy_d;
        end
    end

    assign rom_x     = rom_x_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign busy      = busy_q;

`ifdef TANH_ARB_PERF_EN
    logic [31:0] lookup_cnt_q, lookup_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        lookup_cnt_d = lookup_cnt_q;
        stall_cnt_d  = stall_cnt_q;
        if (xfer && lookup_cnt_q != '1) begin
            lookup_cnt_d = lookup_cnt_q + 32'd1;
        end
        if ((|req_valid) && !xfer && stall_cnt_q != '1) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lookup_cnt_q <= '0;
            stall_cnt_q  <= '0;
        end else begin
            lookup_cnt_q <= lookup_cnt_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign lookup_cnt = lookup_cnt_q;
    assign stall_cnt  = stall_cnt_q;
`endif

endmodule

// File: tb/tb_tanh_lut_arbiter.sv
// tb/tb_tanh_lut_arbiter.sv - randomized bench for tanh_lut_arbiter at ROM_LAT 1 and 3
module tb_tanh_lut_arbiter;
    localparam int N  = 4;
    localparam int IW = 10;
    localparam int DW = 16;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic            en = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N*IW-1:0] req_x = '0;
    logic [N-1:0]    rdy1, rdy3, rv1, rv3;
    logic [IW-1:0]   rx1, rx3;
    logic [DW-1:0]   ro1, ro3, rd1, rd3;
    logic            b1, b3;
`ifdef TANH_ARB_PERF_EN
    logic [31:0]     lc1, sc1, lc3, sc3;
`endif

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] rom_f(input logic [IW-1:0] x);
        return DW'(x * 97) ^ 16'hA5C3;
    endfunction

    // ROM models: combinational table behind ROM_LAT cycles of address delay.
    logic [IW-1:0] d1;
    logic [IW-1:0] d3 [3];
    always @(posedge clk) begin
        d1    <= rx1;
        d3[0] <= rx3;
        d3[1] <= d3[0];
        d3[2] <= d3[1];
    end
    assign ro1 = rom_f(d1);
    assign ro3 = rom_f(d3[2]);

    tanh_lut_arbiter #(.NUM_REQ(N), .IN_WIDTH(IW), .DATA_WIDTH(DW), .ROM_LAT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .en(en), .req_valid(req_valid), .req_x(req_x),
        .req_ready(rdy1), .rom_x(rx1), .rom_out(ro1), .rsp_valid(rv1), .rsp_data(rd1),
        .busy(b1)
`ifdef TANH_ARB_PERF_EN
        , .lookup_cnt(lc1), .stall_cnt(sc1)
`endif
    );

    tanh_lut_arbiter #(.NUM_REQ(N), .IN_WIDTH(IW), .DATA_WIDTH(DW), .ROM_LAT(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .en(en), .req_valid(req_valid), .req_x(req_x),
        .req_ready(rdy3), .rom_x(rx3), .rom_out(ro3), .rsp_valid(rv3), .rsp_data(rd3),
        .busy(b3)
`ifdef TANH_ARB_PERF_EN
        , .lookup_cnt(lc3), .stall_cnt(sc3)
`endif
    );

    typedef struct {
        int            t;
        int            id;
        logic [IW-1:0] x;
    } ent_t;

    ent_t          hist[$];
    int            head [2];
    logic [DW-1:0] last_d [2];
    int            ptr;
    logic [IW-1:0] exp_rx;
    logic [N-1:0]  last_grant;
    int            cyc;
    int            n_tests;
    int            n_fail;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock cycle: compare outputs at the falling edge, then advance the model.
    task automatic step();
        logic [N-1:0]  eg;
        logic [N-1:0]  erv;
        logic [DW-1:0] ed;
        logic          eb;
        int            gid;
        int            lat;
        ent_t          e;
        @(negedge clk);
        eg  = '0;
        gid = -1;
        if (en) begin
            for (int k = 1; k <= N; k++) begin
                if (gid < 0 && req_valid[(ptr + k) % N]) gid = (ptr + k) % N;
            end
        end
        if (gid >= 0) eg[gid] = 1'b1;
        check("req_ready", rdy1, eg);
        check("req_ready_lat3", rdy3, eg);
        check("rom_x", rx1, exp_rx);
        check("rom_x_lat3", rx3, exp_rx);
        for (int d = 0; d < 2; d++) begin
            lat = (d == 0) ? 1 : 3;
            while (head[d] < hist.size() && hist[head[d]].t + 2 + lat < cyc) head[d]++;
            erv = '0;
            ed  = last_d[d];
            if (head[d] < hist.size() && hist[head[d]].t + 2 + lat == cyc) begin
                erv[hist[head[d]].id] = 1'b1;
                ed        = rom_f(hist[head[d]].x);
                last_d[d] = ed;
            end
            eb = (head[d] < hist.size());
            if (d == 0) begin
                check("rsp_valid", rv1, erv);
                check("rsp_data", rd1, ed);
                check("busy", b1, eb);
            end else begin
                check("rsp_valid_lat3", rv3, erv);
                check("rsp_data_lat3", rd3, ed);
                check("busy_lat3", b3, eb);
            end
        end
        last_grant = rdy1;
        if (gid >= 0) begin
            e.t  = cyc;
            e.id = gid;
            e.x  = req_x[gid*IW +: IW];
            hist.push_back(e);
            ptr    = gid;
            exp_rx = e.x;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        req_valid = '0;
        en        = 1'b0;
        rst_n     = 1'b0;
        #1;
        check("rst_rom_x", rx1, 0);
        check("rst_rsp_valid", rv1, 0);
        check("rst_rsp_data", rd1, 0);
        check("rst_busy", b1, 0);
        check("rst_busy_lat3", b3, 0);
        check("rst_rsp_valid_lat3", rv3, 0);
        head[0]   = hist.size();
        head[1]   = hist.size();
        last_d[0] = '0;
        last_d[1] = '0;
        ptr       = N - 1;
        exp_rx    = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc++;
    endtask

    task automatic idle(input int n);
        req_valid = '0;
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        cyc     = 0;
        #1;
        do_reset();

        // Single request from requester 2.
        en = 1'b1;
        req_valid = 4'b0100;
        req_x[2*IW +: IW] = 10'h005;
        step();
        check("single_grant", last_grant, 4'b0100);
        check("single_rom_x", rx1, 10'h005);
        check("single_busy", b1, 1);
        req_valid = '0;
        step();
        step();
        check("single_rsp_valid", rv1, 4'b0100);
        check("single_rsp_data", rd1, rom_f(10'h005));
        idle(5);

        // Full contention from a fresh pointer.
        do_reset();
        en = 1'b1;
        req_valid = 4'b1111;
        for (int i = 0; i < N; i++) req_x[i*IW +: IW] = IW'(10'h100 + i);
        for (int k = 0; k < 8; k++) begin
            step();
            check("contention_grant", last_grant, N'(1) << (k % N));
        end
`ifdef TANH_ARB_PERF_EN
        check("lookup_cnt", lc1, 8);
`endif
        idle(6);

        // Rotation with requesters 1 and 3, then 0 joins.
        req_valid = 4'b0010;
        step();
        check("rot_seed", last_grant, 4'b0010);
        req_valid = 4'b1010;
        step();
        check("rot_g3", last_grant, 4'b1000);
        step();
        check("rot_g1", last_grant, 4'b0010);
        step();
        check("rot_g3b", last_grant, 4'b1000);
        req_valid = 4'b1011;
        step();
        check("rot_g0", last_grant, 4'b0001);
        step();
        check("rot_g1b", last_grant, 4'b0010);
        idle(6);

        // en low mid-stream.
        do_reset();
        en = 1'b1;
        req_valid = 4'b0001;
        step();
        req_valid = 4'b0010;
        step();
        en = 1'b0;
        req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            step();
            check("enlow_no_grant", last_grant, 0);
        end
`ifdef TANH_ARB_PERF_EN
        check("stall_cnt", sc1, 5);
        check("lookup_cnt_enlow", lc1, 2);
`endif
        check("enlow_busy_drained", b1, 0);
        en = 1'b1;
        idle(6);

        // Reset one cycle after a handshake.
        req_valid = 4'b0100;
        step();
        do_reset();
        en = 1'b1;
        req_valid = 4'b1111;
        step();
        check("post_reset_grant", last_grant, 4'b0001);
        idle(6);

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            en        = ($urandom_range(0, 3) != 0);
            req_valid = N'($urandom());
            for (int i = 0; i < N; i++) req_x[i*IW +: IW] = IW'($urandom());
            if ($urandom_range(0, 149) == 0) do_reset();
            else step();
        end
        en = 1'b1;
        idle(8);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
